rotary_encoder_decoder: RTL

- Front-end stage for the TM1638 stimulus path.
- Takes raw, bouncy quadrature (A/B) and push-button pins from a mechanical rotary encoder (EC11-class).
- Synchronizes and debounces them, decodes the Gray-code sequence, and emits the 1-clock pulses (Btn, Left, Right) consumed by the encoder stimulus stage.
- All outputs are registered on the positive clock edge.

---
 rtl/rotary_encoder_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rotary_encoder_decoder.sv
// rtl/rotary_encoder_decoder.sv - synchronize, debounce and decode a quadrature rotary encoder with push-button
module rotary_encoder_decoder #(
    parameter int DEBOUNCE_CLK_CYCLES = 1000,
    parameter int STEPS_PER_DETENT    = 4,
    parameter bit BTN_ACTIVE_LOW      = 1
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Enc_A,
    input  logic i_Enc_B,
    input  logic i_Enc_Btn,
    output logic o_Encoder_Btn,
    output logic o_Encoder_Left,
    output logic o_Encoder_Right,
    output logic o_Btn_Level,
    output logic o_Error
);

    // Channel packing used throughout: bit2 = button, bit1 = A, bit0 = B.
    // Pin rest level: A/B idle high, button pin idle at its not-pressed level.
    localparam logic [2:0] RAW_REST    = {BTN_ACTIVE_LOW, 2'b11};
    // After polarity correction the button reads 0 = not pressed.
    localparam logic [2:0] STABLE_REST = 3'b011;

    localparam logic signed [3:0] STEP_POS = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] STEP_NEG = -STEP_POS;

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] synced;
    logic [2:0] stable;

    assign raw = {i_Enc_Btn, i_Enc_A, i_Enc_B};

    // Two-flop synchronizer per raw pin.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1 <= RAW_REST;
            sync2 <= RAW_REST;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Button polarity is normalised only after the synchronizer so that 1 = pressed.
    assign synced = {sync2[2] ^ BTN_ACTIVE_LOW, sync2[1:0]};

    generate
        if (DEBOUNCE_CLK_CYCLES == 0) begin : g_bypass
            assign stable = synced;
        end else begin : g_filter
            localparam int CNT_W = $clog2(DEBOUNCE_CLK_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLK_CYCLES - 1);

            logic [2:0][CNT_W-1:0] cnt;
            logic [2:0]            stable_q;

            // Per-channel filter: accept a new level only after it has differed for the full window.
            always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                if (!i_Rst_n) begin
                    cnt      <= '0;
                    stable_q <= STABLE_REST;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (synced[i] == stable_q[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            stable_q[i] <= synced[i];
                            cnt[i]      <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    // Position of a quadrature state along the clockwise cycle 11 -> 01 -> 00 -> 10.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b11:   gray_idx = 2'd0;
            2'b01:   gray_idx = 2'd1;
            2'b00:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    logic [1:0]        cur_ab;
    logic [1:0]        prev_ab;
    logic [1:0]        step;
    logic signed [3:0] acc;
    logic signed [3:0] acc_inc;
    logic signed [3:0] acc_dec;

    // Index difference: 1 = clockwise, 3 = counter-clockwise, 2 = both bits flipped (illegal).
    always_comb begin
        cur_ab  = stable[1:0];
        step    = gray_idx(cur_ab) - gray_idx(prev_ab);
        acc_inc = acc + 4'sd1;
        acc_dec = acc - 4'sd1;
    end

    // Quadrature accumulator and registered rotation/error pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            prev_ab         <= 2'b11;
            acc             <= '0;
            o_Encoder_Right <= 1'b0;
            o_Encoder_Left  <= 1'b0;
            o_Error         <= 1'b0;
        end else begin
            o_Encoder_Right <= 1'b0;
            o_Encoder_Left  <= 1'b0;
            o_Error         <= 1'b0;
            prev_ab         <= cur_ab;
            case (step)
                2'd1: begin
                    if (acc_inc == STEP_POS) begin
                        o_Encoder_Right <= 1'b1;
                        acc             <= '0;
                    end else begin
                        acc <= acc_inc;
                    end
                end
                2'd3: begin
                    if (acc_dec == STEP_NEG) begin
                        o_Encoder_Left <= 1'b1;
                        acc            <= '0;
                    end else begin
                        acc <= acc_dec;
                    end
                end
                2'd2: begin
                    o_Error <= 1'b1;
                    acc     <= '0;
                end
                default: begin
                end
            endcase
            // With four steps per detent the rest state 11 is the detent, so re-align there.
            if (STEPS_PER_DETENT == 4 && cur_ab == 2'b11 && prev_ab != 2'b11) begin
                acc <= '0;
            end
        end
    end

    // Button level register and rising-edge press pulse.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Btn_Level   <= 1'b0;
            o_Encoder_Btn <= 1'b0;
        end else begin
            o_Btn_Level   <= stable[2];
            o_Encoder_Btn <= stable[2] & ~o_Btn_Level;
        end
    end

endmodule
